// File: rtl/voice_scheduler.sv
// Voice-state RAM sequencer: clears the RAM after reset, applies MIDI note events, and scans every voice's phase per sample tick.
// Latency: an event is written at its accept edge; the scan result for voice k is registered one cycle after its RAM read (tick+2+k).
// Backpressure: ev_ready is low during clear, during scan and in a tick cycle; a tick arriving mid-scan is dropped and flagged on overrun.
module voice_scheduler #(
    parameter int VOICE_BITS = 4,
    parameter int PHASE_W    = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_tick,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic [VOICE_BITS-1:0]     ev_voice,
    input  logic                      ev_on,
    input  logic [PHASE_W-1:0]        ev_inc,
    output logic [VOICE_BITS-1:0]     ram_addr,
    output logic [2*PHASE_W:0]        ram_din,
    output logic                      ram_we,
    input  logic [2*PHASE_W:0]        ram_dout,
    output logic                      smp_valid,
    output logic [VOICE_BITS-1:0]     smp_voice,
    output logic [PHASE_W-1:0]        smp_phase,
    output logic                      frame_done,
    output logic                      overrun,
    output logic                      busy
);
    localparam logic [VOICE_BITS-1:0] LAST_IDX = {VOICE_BITS{1'b1}};

    typedef struct packed {
        logic               active;
        logic [PHASE_W-1:0] inc;
        logic [PHASE_W-1:0] phase;
    } voice_t;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_SCAN  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [VOICE_BITS-1:0] r_idx;
    logic [VOICE_BITS-1:0] w_idx_nxt;
    voice_t                w_rd;
    voice_t                w_wr;
    logic [PHASE_W-1:0]    w_phase_sum;
    logic                  w_last;
    logic                  w_smp_vld;

    logic                  r_smp_vld;
    logic [VOICE_BITS-1:0] r_smp_voice;
    logic [PHASE_W-1:0]    r_smp_phase;
    logic                  r_frame_done;
    logic                  r_overrun;

    assign w_rd        = ram_dout;
    // Carry out of the phase add is discarded: phase wraps modulo 2**PHASE_W.
    assign w_phase_sum = w_rd.phase + w_rd.inc;
    assign w_last      = (r_idx == LAST_IDX);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wr        = '0;
        w_smp_vld   = 1'b0;
        ram_addr    = r_idx;
        ram_we      = 1'b0;
        ev_ready    = 1'b0;

        case (r_state)
            S_CLEAR: begin
                ram_we    = 1'b1;
                w_idx_nxt = r_idx + 1'b1;
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
            end

            S_IDLE: begin
                ram_addr = ev_voice;
                ev_ready = !sample_tick;
                if (sample_tick) begin
                    w_state_nxt = S_SCAN;
                    w_idx_nxt   = '0;
                end else if (ev_valid) begin
                    ram_we = 1'b1;
                    if (ev_on) begin
                        w_wr.active = 1'b1;
                        w_wr.inc    = ev_inc;
                        w_wr.phase  = '0;
                    end else begin
                        // Note-off keeps inc/phase so the voice can be inspected later.
                        w_wr        = w_rd;
                        w_wr.active = 1'b0;
                    end
                end
            end

            S_SCAN: begin
                w_smp_vld = w_rd.active;
                if (w_rd.active) begin
                    ram_we     = 1'b1;
                    w_wr       = w_rd;
                    w_wr.phase = w_phase_sum;
                end
                w_idx_nxt = r_idx + 1'b1;
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = S_CLEAR;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign ram_din = w_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_CLEAR;
            r_idx        <= '0;
            r_smp_vld    <= 1'b0;
            r_smp_voice  <= '0;
            r_smp_phase  <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_smp_vld    <= w_smp_vld;
            if (w_smp_vld) begin
                r_smp_voice <= r_idx;
                r_smp_phase <= w_phase_sum;
            end
            r_frame_done <= (r_state == S_SCAN) && w_last;
            r_overrun    <= (r_state == S_SCAN) && sample_tick;
        end
    end

    assign smp_valid  = r_smp_vld;
    assign smp_voice  = r_smp_voice;
    assign smp_phase  = r_smp_phase;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: owns the voice RAM and compares DUT traffic against a per-voice note/phase model.
module tb_voice_scheduler;
    localparam int VB = 4;
    localparam int PW = 24;
    localparam int N  = 1 << VB;
    localparam int W  = 2*PW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          sample_tick = 1'b0;
    logic          ev_valid = 1'b0;
    logic          ev_ready;
    logic [VB-1:0] ev_voice = '0;
    logic          ev_on = 1'b0;
    logic [PW-1:0] ev_inc = '0;
    logic [VB-1:0] ram_addr;
    logic [W-1:0]  ram_din;
    logic          ram_we;
    logic [W-1:0]  ram_dout;
    logic          smp_valid;
    logic [VB-1:0] smp_voice;
    logic [PW-1:0] smp_phase;
    logic          frame_done;
    logic          overrun;
    logic          busy;

    voice_scheduler #(.VOICE_BITS(VB), .PHASE_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_voice(ev_voice),
        .ev_on(ev_on), .ev_inc(ev_inc),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .smp_valid(smp_valid), .smp_voice(smp_voice), .smp_phase(smp_phase),
        .frame_done(frame_done), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port RAM: combinational read, write on rising edge.
    logic [W-1:0] mem [N];
    assign ram_dout = mem[ram_addr];
    always @(posedge clk) if (ram_we === 1'b1) mem[ram_addr] <= ram_din;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model: note state per voice plus the queue of samples a frame must emit.
    typedef struct { int v; logic [PW-1:0] p; int c; } exp_t;
    exp_t          exp_q[$];
    logic          act_m [N];
    logic [PW-1:0] inc_m [N];
    logic [PW-1:0] ph_m  [N];

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            act_m[k] = 1'b0; inc_m[k] = '0; ph_m[k] = '0;
        end
    endtask

    task automatic model_event(input int v, input logic on, input logic [PW-1:0] inc);
        if (on) begin
            act_m[v] = 1'b1; inc_m[v] = inc; ph_m[v] = '0;
        end else begin
            act_m[v] = 1'b0;
        end
    endtask

    task automatic model_frame(input int t);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            if (act_m[k]) begin
                ph_m[k] = PW'((64'(ph_m[k]) + 64'(inc_m[k])) % (64'd1 << PW));
                e.v = k; e.p = ph_m[k]; e.c = t + 2 + k;
                exp_q.push_back(e);
            end
        end
    endtask

    int fd_cnt = 0, fd_last = -1, ov_cnt = 0, ov_last = -1;

    always @(negedge clk) begin
        exp_t e;
        if (smp_valid === 1'b1) begin
            check("smp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("smp_voice", 64'(smp_voice), 64'(e.v));
                check("smp_phase", 64'(smp_phase), 64'(e.p));
                check("smp_cycle", 64'(cyc), 64'(e.c));
            end
        end
        if (frame_done === 1'b1) begin fd_cnt++; fd_last = cyc; end
        if (overrun === 1'b1)    begin ov_cnt++; ov_last = cyc; end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check_ram(input string tag);
        for (int k = 0; k < N; k++)
            check(tag, 64'(mem[k]), 64'({act_m[k], inc_m[k], ph_m[k]}));
    endtask

    task automatic check_reset_outputs();
        check("rst_smp_valid", 64'(smp_valid), 64'd0);
        check("rst_smp_voice", 64'(smp_voice), 64'd0);
        check("rst_smp_phase", 64'(smp_phase), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_ev_ready", 64'(ev_ready), 64'd0);
    endtask

    // Called at posedge+1; CLEAR must hold busy for exactly N cycles.
    task automatic reset_release();
        rst_n = 1'b1;
        for (int c = 0; c < N; c++) begin
            #1;
            check("clear_busy", 64'(busy), 64'd1);
            check("clear_ev_ready", 64'(ev_ready), 64'd0);
            step();
        end
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_ev_ready", 64'(ev_ready), 64'd1);
        step();
        check_ram("ram_cleared");
    endtask

    task automatic send_ev(input int v, input logic on, input logic [PW-1:0] inc);
        int waited = 0;
        bit acc = 0;
        ev_valid = 1'b1; ev_voice = VB'(v); ev_on = on; ev_inc = inc;
        for (int i = 0; i < 3*N && !acc; i++) begin
            #1;
            if (ev_ready === 1'b1) acc = 1;
            else waited++;
            step();
        end
        ev_valid = 1'b0;
        check("ev_accepted", 64'(acc), 64'd1);
        check("ev_wait_cycles", 64'(waited), 64'd0);
        if (acc) model_event(v, on, inc);
        check("ev_ram_word", 64'(mem[v]), 64'({act_m[v], inc_m[v], ph_m[v]}));
    endtask

    task automatic do_frame();
        int t, fd0, ov0;
        fd0 = fd_cnt; ov0 = ov_cnt;
        t = cyc;
        sample_tick = 1'b1;
        model_frame(t);
        step();
        sample_tick = 1'b0;
        repeat (N + 1) step();
        check("frame_done_count", 64'(fd_cnt - fd0), 64'd1);
        check("frame_done_cycle", 64'(fd_last), 64'(t + N + 1));
        check("frame_missing_smp", 64'(exp_q.size()), 64'd0);
        check("frame_no_overrun", 64'(ov_cnt - ov0), 64'd0);
        check("frame_idle", 64'(busy), 64'd0);
        check_ram("frame_ram");
    endtask

    initial begin
        logic [W-1:0]  want;
        logic [31:0]   r32;
        int            t, fd0, ov0;

        #500000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0]  want;
        logic [PW-1:0] ph0;
        logic [31:0]   r32;
        int            t, fd0, ov0, nev;

        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) step();
        #1;
        check_reset_outputs();
        step();
        reset_release();

        // Empty RAM: a frame emits no samples.
        do_frame();

        // Single voice, two frames, then note-off keeps inc/phase.
        send_ev(3, 1'b1, 24'h000100);
        do_frame();
        do_frame();
        send_ev(3, 1'b0, '0);
        want = {1'b0, 24'h000100, 24'h000200};
        check("noteoff_word", 64'(mem[3]), 64'(want));
        do_frame();

        // Phase wrap-around on voice 0.
        send_ev(0, 1'b1, 24'h800000);
        do_frame();
        ph0 = mem[0][PW-1:0];
        check("wrap_phase_1", 64'(ph0), 64'h800000);
        do_frame();
        ph0 = mem[0][PW-1:0];
        check("wrap_phase_2", 64'(ph0), 64'h000000);
        do_frame();
        ph0 = mem[0][PW-1:0];
        check("wrap_phase_3", 64'(ph0), 64'h800000);

        // Retrigger restarts phase at 0.
        send_ev(3, 1'b1, 24'h000100);
        want = {1'b1, 24'h000100, 24'h000000};
        check("retrigger_word", 64'(mem[3]), 64'(want));

        // Tick and event together: event stalls through scan, second tick overruns.
        fd0 = fd_cnt; ov0 = ov_cnt;
        t = cyc;
        sample_tick = 1'b1;
        ev_valid = 1'b1; ev_voice = VB'(5); ev_on = 1'b1; ev_inc = 24'h012345;
        model_frame(t);
        #1;
        check("tick_ev_ready", 64'(ev_ready), 64'd0);
        step();
        for (int c = 1; c <= N; c++) begin
            sample_tick = (c == 5);
            #1;
            check("scan_ev_ready", 64'(ev_ready), 64'd0);
            check("scan_busy", 64'(busy), 64'd1);
            step();
        end
        sample_tick = 1'b0;
        #1;
        check("stall_accept_ready", 64'(ev_ready), 64'd1);
        check("stall_accept_cycle", 64'(cyc), 64'(t + N + 1));
        step();
        ev_valid = 1'b0;
        model_event(5, 1'b1, 24'h012345);
        check("overrun_count", 64'(ov_cnt - ov0), 64'd1);
        check("overrun_cycle", 64'(ov_last), 64'(t + 6));
        check("stall_frame_done_count", 64'(fd_cnt - fd0), 64'd1);
        check("stall_frame_done_cycle", 64'(fd_last), 64'(t + N + 1));
        check("stall_missing_smp", 64'(exp_q.size()), 64'd0);
        check_ram("stall_ram");

        // Randomized events interleaved with frames.
        for (int it = 0; it < 24; it++) begin
            nev = $urandom_range(0, 3);
            for (int e = 0; e < nev; e++) begin
                r32 = $urandom;
                send_ev($urandom_range(0, N-1), ($urandom_range(0, 2) != 0), r32[PW-1:0]);
            end
            repeat ($urandom_range(0, 2)) step();
            do_frame();
        end

        // Reset during scan cycle k=8 with voices 3 and 12 active.
        send_ev(3, 1'b1, 24'h000100);
        send_ev(12, 1'b1, 24'h000345);
        t = cyc;
        sample_tick = 1'b1;
        model_frame(t);
        step();
        sample_tick = 1'b0;
        repeat (8) step();
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check_reset_outputs();
        step();
        step();
        reset_release();
        do_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
